// File: rtl/microsequencer_pkg.sv
// Shared widths, microword field positions, opcodes, entry offsets and FSM
// encoding for the microsequencer and its dispatch ROM.
package microsequencer_pkg;

    localparam int OFFSET_WIDTH = 6;
    localparam int MCROM_WIDTH  = 16;
    localparam int OPCODE_WIDTH = 6;
    localparam int CNT_WIDTH    = 16;

    localparam int SEQ_SEL_BIT = MCROM_WIDTH - 1;
    localparam int NEXT_MSB    = MCROM_WIDTH - 2;
    localparam int NEXT_LSB    = NEXT_MSB - OFFSET_WIDTH + 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_CLR  = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ST   = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_INC  = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_CMPI = 6'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP  = 6'h07;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 6'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOR  = 6'h0a;
    localparam logic [OPCODE_WIDTH-1:0] OP_NAND = 6'h0b;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'h0c;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = 6'h0d;
    localparam logic [OPCODE_WIDTH-1:0] OP_SRA  = 6'h0e;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLA  = 6'h0f;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 6'h3f;
    // Conditional branches occupy 0x20-0x27; low three bits pick the condition.
    localparam logic [2:0] OP_BR_HI = 3'b100;

    localparam logic [OFFSET_WIDTH-1:0] OFF_FETCH    = 6'h00;
    localparam logic [OFFSET_WIDTH-1:0] OFF_DECODE   = 6'h01;
    localparam logic [OFFSET_WIDTH-1:0] OFF_BR_TAKEN = 6'h0e;
    localparam logic [OFFSET_WIDTH-1:0] OFF_BR_NOT   = 6'h0f;
    localparam logic [OFFSET_WIDTH-1:0] OFF_HALT     = 6'h3f;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } seq_state_t;

    // flags = {V,C,N,Z}
    function automatic logic cond_true(input logic [2:0] cc, input logic [3:0] flags);
        case (cc)
            3'd0:    return 1'b1;
            3'd1:    return flags[0];
            3'd2:    return !flags[0];
            3'd3:    return flags[1];
            3'd4:    return !flags[1];
            3'd5:    return flags[2];
            3'd6:    return !flags[2];
            default: return flags[3];
        endcase
    endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Sequencer-side bundle: ROM word and decode inputs in, ROM address and
// control/status out. master = surrounding CPU/ROM, slave = sequencer.
interface microsequencer_if;
    import microsequencer_pkg::*;

    logic [MCROM_WIDTH-1:0]  mc_word;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [3:0]              flags;
    logic                    run;
    logic                    step_req;
    logic [OFFSET_WIDTH-1:0] offset;
    logic                    uop_valid;
    logic                    instr_retired;
    logic                    step_ack;
    logic                    halted;
    logic [CNT_WIDTH-1:0]    retired_count;
    seq_state_t              state;

    // Handshake: step_req is a one-cycle request sampled only in STOP;
    // step_ack is a one-cycle completion pulse, never asserted for a step
    // that lost to run or ended in HALT.
    modport master (
        output mc_word, opcode, flags, run, step_req,
        input  offset, uop_valid, instr_retired, step_ack, halted, retired_count, state
    );

    modport slave (
        input  mc_word, opcode, flags, run, step_req,
        output offset, uop_valid, instr_retired, step_ack, halted, retired_count, state
    );

endinterface

// File: rtl/microsequencer_dispatch_rom.sv
// Combinational opcode+flags to microcode entry offset map used at decode.
module microsequencer_dispatch_rom
    import microsequencer_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [3:0]              flags,
    output logic [OFFSET_WIDTH-1:0] target
);

    always_comb begin
        target = OFF_HALT;
        if (opcode[5:3] == OP_BR_HI) begin
            target = cond_true(opcode[2:0], flags) ? OFF_BR_TAKEN : OFF_BR_NOT;
        end else begin
            case (opcode)
                OP_CLR:  target = 6'h02;
                OP_LDI:  target = 6'h03;
                OP_LD:   target = 6'h04;
                OP_ST:   target = 6'h08;
                OP_ADD:  target = 6'h0a;
                OP_INC:  target = 6'h10;
                OP_CMPI: target = 6'h11;
                OP_CMP:  target = 6'h12;
                OP_SUB:  target = 6'h16;
                OP_XOR:  target = 6'h1a;
                OP_NOR:  target = 6'h1e;
                OP_NAND: target = 6'h22;
                OP_ADDI: target = 6'h26;
                OP_NOT:  target = 6'h27;
                OP_SRA:  target = 6'h28;
                OP_SLA:  target = 6'h29;
                // HLT and every unassigned opcode land on the halt word
                default: target = OFF_HALT;
            endcase
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microcode address sequencer: next-address mux, run/stop/step/halt FSM and
// retired-instruction counter.
module microsequencer
    import microsequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    microsequencer_if.slave bus
);

    seq_state_t              state;
    logic [OFFSET_WIDTH-1:0] cur_offset;
    logic [CNT_WIDTH-1:0]    count;
    logic                    step_ack_q;

    logic                    seq_sel;
    logic [OFFSET_WIDTH-1:0] next_field;
    logic [OFFSET_WIDTH-1:0] dispatch_target;
    logic [OFFSET_WIDTH-1:0] next_offset;
    logic [OFFSET_WIDTH-1:0] offset;
    logic                    stop_boundary;
    logic                    advance;
    logic                    retire;
    logic                    to_halt;

    assign seq_sel    = bus.mc_word[SEQ_SEL_BIT];
    assign next_field = bus.mc_word[NEXT_MSB:NEXT_LSB];

    microsequencer_dispatch_rom u_dispatch (
        .opcode (bus.opcode),
        .flags  (bus.flags),
        .target (dispatch_target)
    );

    always_comb begin
        next_offset   = seq_sel ? next_field : dispatch_target;
        // RUN only stops on a fetch word, so a started instruction always finishes
        stop_boundary = (state == ST_RUN) && (cur_offset == OFF_FETCH) && !bus.run;
        advance       = rst_n && (((state == ST_RUN) && !stop_boundary) || (state == ST_STEP));
        retire        = advance && seq_sel && (next_field == OFF_FETCH);
        to_halt       = advance && (next_offset == OFF_HALT);
        if (!rst_n) begin
            offset = OFF_FETCH;
        end else if (state == ST_HALT) begin
            offset = OFF_HALT;
        end else if (advance) begin
            offset = next_offset;
        end else begin
            offset = cur_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_STOP;
            cur_offset <= OFF_FETCH;
            count      <= '0;
            step_ack_q <= 1'b0;
        end else begin
            cur_offset <= offset;
            step_ack_q <= 1'b0;
            if (retire) begin
                count <= count + 1'b1;
            end
            case (state)
                ST_STOP: begin
                    if (bus.run) begin
                        state <= ST_RUN;
                    end else if (bus.step_req) begin
                        state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (stop_boundary) begin
                        state <= ST_STOP;
                    end else if (to_halt) begin
                        state <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    if (to_halt) begin
                        state <= ST_HALT;
                    end else if (retire) begin
                        state      <= ST_STOP;
                        step_ack_q <= 1'b1;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    assign bus.offset        = offset;
    assign bus.uop_valid     = advance;
    assign bus.instr_retired = retire;
    assign bus.step_ack      = rst_n && step_ack_q;
    assign bus.halted        = rst_n && (state == ST_HALT);
    assign bus.retired_count = count;
    assign bus.state         = state;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: behavioural one-cycle microcode ROM, per-cycle
// script table, dispatch vector table and halt / counter-wrap sequences.
module tb_microsequencer;
    import microsequencer_pkg::*;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic clk;
    logic rst_n;
    microsequencer_if bus();

    microsequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [MCROM_WIDTH-1:0] rom [64];
    always @(posedge clk) bus.mc_word <= rom[bus.offset];

    int checks = 0;
    int errors = 0;
    logic [OFFSET_WIDTH-1:0] exp_q[$];

    typedef struct {
        logic                    run;
        logic                    step;
        logic [OFFSET_WIDTH-1:0] off;
        logic                    uv;
        logic                    ret;
        logic                    ack;
        logic                    hlt;
    } row_t;

    typedef struct {
        logic [OPCODE_WIDTH-1:0] op;
        logic [3:0]              fl;
        logic [OFFSET_WIDTH-1:0] exp;
    } dvec_t;

    row_t  script [33];
    dvec_t dvec   [31];

    function automatic logic [MCROM_WIDTH-1:0] mk(input logic s, input logic [OFFSET_WIDTH-1:0] n);
        logic [MCROM_WIDTH-1:0] w;
        w = '0;
        w[SEQ_SEL_BIT] = s;
        w[NEXT_MSB:NEXT_LSB] = n;
        return w;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_row(input string tag, input row_t r);
        check({tag, " offset"},        32'(bus.offset),        32'(r.off));
        check({tag, " uop_valid"},     32'(bus.uop_valid),     32'(r.uv));
        check({tag, " instr_retired"}, 32'(bus.instr_retired), 32'(r.ret));
        check({tag, " step_ack"},      32'(bus.step_ack),      32'(r.ack));
        check({tag, " halted"},        32'(bus.halted),        32'(r.hlt));
    endtask

    // ---------------- driver tasks ----------------
    // Leaves rst_n low at a falling edge; the caller releases it.
    task automatic apply_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.step_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.step_req = 1'b0;
        bus.opcode   = OP_LD;
        bus.flags    = 4'b0000;

        for (int i = 0; i < 64; i++) rom[i] = mk(1'b1, 6'h00);
        rom[0]  = mk(1'b1, 6'h01);
        rom[1]  = mk(1'b0, 6'h00);
        rom[4]  = mk(1'b1, 6'h05);
        rom[5]  = mk(1'b1, 6'h06);
        rom[6]  = mk(1'b1, 6'h07);
        rom[63] = mk(1'b1, 6'h3f);

        // run, step, offset, uop_valid, retired, step_ack, halted
        script[0]  = '{T, F, 6'h00, F, F, F, F};
        script[1]  = '{T, F, 6'h01, T, F, F, F};
        script[2]  = '{T, F, 6'h04, T, F, F, F};
        script[3]  = '{T, F, 6'h05, T, F, F, F};
        script[4]  = '{T, F, 6'h06, T, F, F, F};
        script[5]  = '{T, F, 6'h07, T, F, F, F};
        script[6]  = '{T, F, 6'h00, T, T, F, F};
        script[7]  = '{T, F, 6'h01, T, F, F, F};
        script[8]  = '{T, F, 6'h04, T, F, F, F};
        script[9]  = '{T, F, 6'h05, T, F, F, F};
        script[10] = '{F, F, 6'h06, T, F, F, F};
        script[11] = '{F, F, 6'h07, T, F, F, F};
        script[12] = '{F, F, 6'h00, T, T, F, F};
        script[13] = '{F, F, 6'h00, F, F, F, F};
        script[14] = '{F, F, 6'h00, F, F, F, F};
        script[15] = '{F, T, 6'h00, F, F, F, F};
        script[16] = '{F, F, 6'h01, T, F, F, F};
        script[17] = '{F, F, 6'h04, T, F, F, F};
        script[18] = '{F, F, 6'h05, T, F, F, F};
        script[19] = '{F, F, 6'h06, T, F, F, F};
        script[20] = '{F, F, 6'h07, T, F, F, F};
        script[21] = '{F, F, 6'h00, T, T, F, F};
        script[22] = '{F, F, 6'h00, F, F, T, F};
        script[23] = '{F, F, 6'h00, F, F, F, F};
        script[24] = '{T, T, 6'h00, F, F, F, F};
        script[25] = '{T, F, 6'h01, T, F, F, F};
        script[26] = '{F, F, 6'h04, T, F, F, F};
        script[27] = '{F, T, 6'h05, T, F, F, F};
        script[28] = '{F, F, 6'h06, T, F, F, F};
        script[29] = '{F, F, 6'h07, T, F, F, F};
        script[30] = '{F, F, 6'h00, T, T, F, F};
        script[31] = '{F, F, 6'h00, F, F, F, F};
        script[32] = '{F, F, 6'h00, F, F, F, F};

        dvec[0]  = '{6'h00, 4'b0000, 6'h02};
        dvec[1]  = '{6'h01, 4'b0000, 6'h03};
        dvec[2]  = '{6'h02, 4'b0000, 6'h04};
        dvec[3]  = '{6'h03, 4'b0000, 6'h08};
        dvec[4]  = '{6'h04, 4'b0000, 6'h0a};
        dvec[5]  = '{6'h05, 4'b0000, 6'h10};
        dvec[6]  = '{6'h06, 4'b0000, 6'h11};
        dvec[7]  = '{6'h07, 4'b0000, 6'h12};
        dvec[8]  = '{6'h08, 4'b0000, 6'h16};
        dvec[9]  = '{6'h09, 4'b0000, 6'h1a};
        dvec[10] = '{6'h0a, 4'b0000, 6'h1e};
        dvec[11] = '{6'h0b, 4'b0000, 6'h22};
        dvec[12] = '{6'h0c, 4'b0000, 6'h26};
        dvec[13] = '{6'h0d, 4'b0000, 6'h27};
        dvec[14] = '{6'h0e, 4'b0000, 6'h28};
        dvec[15] = '{6'h0f, 4'b0000, 6'h29};
        dvec[16] = '{6'h3f, 4'b0000, 6'h3f};
        dvec[17] = '{6'h13, 4'b0000, 6'h3f};
        dvec[18] = '{6'h28, 4'b1111, 6'h3f};
        dvec[19] = '{6'h20, 4'b0000, 6'h0e};
        dvec[20] = '{6'h21, 4'b0001, 6'h0e};
        dvec[21] = '{6'h21, 4'b0000, 6'h0f};
        dvec[22] = '{6'h22, 4'b0000, 6'h0e};
        dvec[23] = '{6'h22, 4'b0001, 6'h0f};
        dvec[24] = '{6'h23, 4'b0010, 6'h0e};
        dvec[25] = '{6'h24, 4'b0010, 6'h0f};
        dvec[26] = '{6'h25, 4'b0100, 6'h0e};
        dvec[27] = '{6'h26, 4'b0100, 6'h0f};
        dvec[28] = '{6'h26, 4'b1011, 6'h0e};
        dvec[29] = '{6'h27, 4'b1000, 6'h0e};
        dvec[30] = '{6'h27, 4'b0111, 6'h0f};

        // ---- reset state ----
        apply_reset();
        settle();
        check_row("reset", '{F, F, 6'h00, F, F, F, F});
        check("reset retired_count", 32'(bus.retired_count), 32'h0);

        // ---- per-cycle script: LD in RUN, stop mid-instruction, step, run+step ----
        rst_n = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i > 0) @(negedge clk);
            bus.run      = script[i].run;
            bus.step_req = script[i].step;
            settle();
            check_row($sformatf("script[%0d]", i), script[i]);
            if (i == 7) check("first retire count", 32'(bus.retired_count), 32'h1);
        end
        check("script retired_count", 32'(bus.retired_count), 32'h4);

        // ---- dispatch vectors, each executed as one step from reset ----
        for (int v = 0; v < 31; v++) begin
            apply_reset();
            bus.opcode   = dvec[v].op;
            bus.flags    = dvec[v].fl;
            exp_q.push_back(dvec[v].exp);
            rst_n        = 1'b1;
            bus.step_req = 1'b1;
            @(negedge clk);
            bus.step_req = 1'b0;
            settle();
            check($sformatf("dvec[%0d] decode offset", v), 32'(bus.offset), 32'h01);
            @(negedge clk);
            settle();
            check($sformatf("dvec[%0d] dispatch op=%0h fl=%0b", v, dvec[v].op, dvec[v].fl),
                  32'(bus.offset), 32'(exp_q.pop_front()));
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                settle();
                if (bus.step_ack || bus.halted) break;
            end
            check($sformatf("dvec[%0d] halted", v),   32'(bus.halted),   32'(dvec[v].exp == 6'h3f));
            check($sformatf("dvec[%0d] step_ack", v), 32'(bus.step_ack), 32'(dvec[v].exp != 6'h3f));
            check($sformatf("dvec[%0d] retired_count", v), 32'(bus.retired_count),
                  32'(dvec[v].exp != 6'h3f));
        end

        // ---- illegal opcode in RUN: halt is sticky until reset ----
        apply_reset();
        bus.opcode = 6'h13;
        bus.flags  = 4'b0000;
        rst_n      = 1'b1;
        bus.run    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        settle();
        check("illegal dispatch offset", 32'(bus.offset), 32'h3f);
        check("illegal dispatch uop_valid", 32'(bus.uop_valid), 32'h1);
        check("illegal halted not yet", 32'(bus.halted), 32'h0);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            bus.run      = 1'($urandom_range(0, 1));
            bus.step_req = 1'($urandom_range(0, 1));
            settle();
            check("halt sticky", 32'({bus.halted, bus.uop_valid, bus.step_ack, bus.instr_retired, bus.offset}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 6'h3f}));
        end
        @(negedge clk);
        rst_n = 1'b0;
        settle();
        check("halt cleared by reset", 32'(bus.halted), 32'h0);
        check("offset during reset", 32'(bus.offset), 32'h00);

        // ---- counter wrap: one-word instruction at fetch, retires every cycle ----
        apply_reset();
        rom[0] = mk(1'b1, 6'h00);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        bus.run = 1'b1;
        for (int n = 0; n < 70000 && bus.retired_count != 16'hffff; n++) @(negedge clk);
        bus.run = 1'b0;
        settle();
        check("wrap preset count", 32'(bus.retired_count), 32'hffff);
        check("wrap stop no retire", 32'(bus.instr_retired), 32'h0);
        @(negedge clk);
        bus.step_req = 1'b1;
        settle();
        check("wrap stopped uop_valid", 32'(bus.uop_valid), 32'h0);
        @(negedge clk);
        bus.step_req = 1'b0;
        settle();
        check("wrap step retire", 32'(bus.instr_retired), 32'h1);
        @(negedge clk);
        settle();
        check("wrap count to zero", 32'(bus.retired_count), 32'h0);
        check("wrap step_ack", 32'(bus.step_ack), 32'h1);
        rom[0] = mk(1'b1, 6'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
# microsequencer

Control-flow engine of the microcoded accumulator CPU; the address-generating counterpart of the microcode ROM. It drives the ROM `offset` and consumes the sequencing field of the returned `mc_word`. It dispatches on the instruction opcode at decode and resolves conditional branches from the ALU flags. It also provides run/stop/single-step/halt control and gates datapath control bits via `uop_valid`.

## Interface
- `OFFSET_WIDTH`, 6: microcode address width; shared define.
- `MCROM_WIDTH`, shared define: microcode word width.
- `OPCODE_WIDTH`, 6: instruction opcode width.
- `CNT_WIDTH`, 16: retired-instruction counter width.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mc_word`  in  MCROM_WIDTH  registered ROM output. Bit [MSB] = `seq_sel` (1: take next field, 0: dispatch). Bits [MSB-1 -: OFFSET_WIDTH] = `next`. Remaining bits are ignored.
- `opcode`  in  OPCODE_WIDTH  instruction register opcode; valid while the decode word (0x01) is on `mc_word`.
- `flags`  in  4  {V,C,N,Z} from the flag register.
- `run`  in  1  level: free-run enable.
- `step_req`  in  1  single-cycle pulse: execute one instruction while stopped.
- `offset`  out  OFFSET_WIDTH  ROM address (combinational).
- `uop_valid`  out  1  word on `mc_word` executes this cycle; gates all datapath enables.
- `instr_retired`  out  1  pulse: the last micro-op of an instruction executed.
- `step_ack`  out  1  pulse: the requested step completed.
- `halted`  out  1  sequencer is in HALT.
- `retired_count`  out  CNT_WIDTH  retired-instruction counter, wraps.

## Operation
- Register `cur_offset` holds the address of the word currently on `mc_word`. Each clock, `cur_offset <= offset`.
- `advance` = state is RUN or STEP, and not a RUN-stop boundary (defined below).
- `offset` = `advance` ? `next_offset` : `cur_offset`. When not advancing, the ROM re-reads the same word, so the micro-op stalls.
- `next_offset`:
  - If `seq_sel`=1: `next`.
  - If `seq_sel`=0: dispatch(opcode, flags).
- Dispatch map: CLR 0x00→0x02, LDI 0x01→0x03, LD 0x02→0x04, ST 0x03→0x08, ADD 0x04→0x0a, INC 0x05→0x10, CMPI 0x06→0x11, CMP 0x07→0x12, SUB 0x08→0x16, XOR 0x09→0x1a, NOR 0x0a→0x1e, NAND 0x0b→0x22, ADDI 0x0c→0x26, NOT 0x0d→0x27, SRA 0x0e→0x28, SLA 0x0f→0x29, HLT 0x3f→0x3f.
- Branches 0x20–0x27: condition code = opcode[2:0]; 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 !C, 7 V. Condition true → 0x0e, false → 0x0f.
- Any other opcode → 0x3f (illegal = halt).
- `uop_valid` = `advance`.
- `instr_retired` = `advance` & `seq_sel` & (`next`==0).
- `retired_count` increments on `instr_retired` and wraps to 0.
- States: STOP, RUN, STEP, HALT.
  - STOP: `run`=1 → RUN. Else `step_req`=1 → STEP.
  - RUN: if `cur_offset`==0 and `run`=0 (stop boundary), no advance and go to STOP. Otherwise advance.
  - STEP: advance. On `instr_retired` → STOP, with `step_ack` asserted the following cycle.
  - RUN/STEP with `advance` and `next_offset`==all-ones → HALT.
  - HALT: no advance; `offset` = 0x3f. Exits only via reset.
- HALT has priority over the STEP→STOP transition.

## Timing
- Reset (`rst_n`=0 at an edge): state STOP, `cur_offset`=0, `retired_count`=0. While `rst_n`=0: `offset`=0, and `uop_valid`, `instr_retired`, `step_ack`, `halted` are all 0.
- The ROM latches word 0x00 during reset, so the fetch word is valid on the first cycle after release.
- The ROM has one-cycle latency. The word for `offset` issued in cycle t is on `mc_word` in t+1. `offset` depends combinationally on `mc_word`, `opcode`, and `flags` in the same cycle.
- STOP→RUN costs one stall cycle; the first `uop_valid` comes the cycle after `run` is seen.
- Dropping `run` mid-instruction: the instruction completes. The sequencer stops on the next fetch boundary without executing the fetch.
- `step_req` while in RUN, STEP, or HALT is ignored. If `run` and `step_req` are both 1 in STOP, `run` wins and no `step_ack` is generated.
- Reset asserted mid-instruction aborts immediately; no retire is counted.

## Structure
- `microcodedefs.v` gains:
  - `SEQ_SEL_BIT`, `NEXT_MSB`, `NEXT_LSB` field positions.
  - `OPCODE_WIDTH` and the opcode defines.
  - Entry offsets: `OFF_FETCH`, `OFF_DECODE`, `OFF_BR_TAKEN`, `OFF_BR_NOT`, `OFF_HALT`.
  - State encodings.
- `microcodeundefs.v` undefines all of the above.
- One sub-module: `dispatch_rom`, a combinational opcode+flags→offset map. The FSM, counter, and `offset` mux stay in `microsequencer`.

## Test plan
- Reset released with `run`=1, ROM word 0x00 = seq 1/next 0x01 → `offset` sequence 0x01, then dispatch. `uop_valid`=1 from the second cycle after release.
- Decode with opcode 0x02 (LD) → `offset` 0x04, 0x05, 0x06, 0x07, 0x00. `instr_retired` pulses once; `retired_count` goes 0→1.
- Opcode 0x21 (BZ):
  - Z=1 → `offset` 0x0e.
  - Z=0 → `offset` 0x0f.
  - Opcode 0x20 with all flags 0 → 0x0e.
- `run`=0 during LD at offset 0x05 → 0x06, 0x07 complete. STOP entered at `cur_offset` 0; `offset` holds 0x00 and `uop_valid`=0. Then `step_req` → one instruction executes, then `step_ack` pulses once.
- Opcode 0x13 (illegal) → `offset` 0x3f, `halted`=1 next cycle. `halted` stays 1 for 100 cycles regardless of `run`/`step_req`. `rst_n`=0 clears it.
- `retired_count` preset to 0xFFFF by 65535 single-micro-op instructions (CLR loop) → next retire gives 0x0000.
